// File: rtl/cr16_pkg.sv
// cr16_pkg: processor-wide word type and register-file size defaults.
`default_nettype none

package cr16_pkg;

   localparam int CR16_DATA_WIDTH = 16;
   localparam int CR16_REG_COUNT  = 16;
   localparam int CR16_ADDR_WIDTH = $clog2(CR16_REG_COUNT);

   typedef logic [CR16_DATA_WIDTH-1:0] cr16_word_t;

endpackage : cr16_pkg

`default_nettype wire

// File: rtl/register_cell.sv
// register_cell: one WIDTH-bit storage word with load enable and asynchronous clear.
`default_nettype none

module register_cell
   import cr16_pkg::*;
#(
   parameter int WIDTH = CR16_DATA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule : register_cell

`default_nettype wire

// File: rtl/register_file.sv
// register_file: one write port, two registered read ports; REGFILE_BYPASS_EN
// forwards a same-cycle write to the reads, otherwise reads see the old value.
`default_nettype none

module register_file
   import cr16_pkg::*;
#(
   parameter int DATA_WIDTH = CR16_DATA_WIDTH,
   parameter int REG_COUNT  = CR16_REG_COUNT,
   parameter int ADDR_WIDTH = CR16_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr_a,
   input  logic [ADDR_WIDTH-1:0] rd_addr_b,
   output logic [DATA_WIDTH-1:0] rd_data_a,
   output logic [DATA_WIDTH-1:0] rd_data_b,
   output logic                  rd_valid
);

   logic [DATA_WIDTH-1:0] w_cell_q [REG_COUNT];
   logic [REG_COUNT-1:0]  w_cell_en;
   logic [DATA_WIDTH-1:0] w_mux_a;
   logic [DATA_WIDTH-1:0] w_mux_b;
   logic                  w_fwd_a;
   logic                  w_fwd_b;
   logic [DATA_WIDTH-1:0] rd_data_a_d;
   logic [DATA_WIDTH-1:0] rd_data_b_d;
   logic [DATA_WIDTH-1:0] rd_data_a_q;
   logic [DATA_WIDTH-1:0] rd_data_b_q;
   logic                  rd_valid_q;

   // An out-of-range wr_addr matches no cell, so the write is dropped.
   for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_cells
      assign w_cell_en[gi] = wr_en && (wr_addr == ADDR_WIDTH'(gi));

      register_cell #(
         .WIDTH (DATA_WIDTH)
      ) u_cell (
         .clk  (clk),
         .rst  (rst),
         .en_i (w_cell_en[gi]),
         .d_i  (wr_data),
         .q_o  (w_cell_q[gi])
      );
   end

   // Unmatched (out-of-range) read indices fall through to zero.
   always_comb begin
      w_mux_a = '0;
      w_mux_b = '0;
      for (int i = 0; i < REG_COUNT; i++) begin
         if (rd_addr_a == ADDR_WIDTH'(i)) begin
            w_mux_a = w_cell_q[i];
         end
         if (rd_addr_b == ADDR_WIDTH'(i)) begin
            w_mux_b = w_cell_q[i];
         end
      end
   end

`ifdef REGFILE_BYPASS_EN
   assign w_fwd_a = (|w_cell_en) && (wr_addr == rd_addr_a);
   assign w_fwd_b = (|w_cell_en) && (wr_addr == rd_addr_b);
`else
   assign w_fwd_a = 1'b0;
   assign w_fwd_b = 1'b0;
`endif

   assign rd_data_a_d = w_fwd_a ? wr_data : w_mux_a;
   assign rd_data_b_d = w_fwd_b ? wr_data : w_mux_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_a_q <= '0;
         rd_data_b_q <= '0;
         rd_valid_q  <= 1'b0;
      end else begin
         rd_data_a_q <= rd_data_a_d;
         rd_data_b_q <= rd_data_b_d;
         rd_valid_q  <= 1'b1;
      end
   end

   assign rd_data_a = rd_data_a_q;
   assign rd_data_b = rd_data_b_q;
   assign rd_valid  = rd_valid_q;

endmodule : register_file

`default_nettype wire

// File: tb/tb_register_file.sv
// tb_register_file: directed and randomized checks of register_file against an array model.
`default_nettype none

module tb_register_file;

   localparam int DW = 16;
   localparam int RC = 16;
   localparam int AW = 4;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] rd_addr_a;
   logic [AW-1:0] rd_addr_b;
   logic [DW-1:0] rd_data_a;
   logic [DW-1:0] rd_data_b;
   logic          rd_valid;

   int n_checks = 0;
   int n_pass   = 0;

   register_file #(
      .DATA_WIDTH (DW),
      .REG_COUNT  (RC),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .rd_valid  (rd_valid)
   );

   always #5 clk = ~clk;

   // Reference: plain array plus the values each read port must show.
   logic [DW-1:0] m_mem [RC];
   logic [DW-1:0] m_a;
   logic [DW-1:0] m_b;
   logic          m_v;

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      if (int'(a) >= RC) return '0;
      if (BYPASS && wr_en && wr_addr == a) return wr_data;
      return m_mem[a];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RC; i++) m_mem[i] <= '0;
         m_a <= '0;
         m_b <= '0;
         m_v <= 1'b0;
      end else begin
         m_a <= model_read(rd_addr_a);
         m_b <= model_read(rd_addr_b);
         m_v <= 1'b1;
         if (wr_en && int'(wr_addr) < RC) m_mem[wr_addr] <= wr_data;
      end
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      check("model_rd_a", rd_data_a, m_a);
      check("model_rd_b", rd_data_b, m_b);
      check("model_valid", {15'd0, rd_valid}, {15'd0, m_v});
   end

   task automatic drive(input logic we, input int wa, input logic [DW-1:0] wd,
                        input int ra, input int rb);
      wr_en     = we;
      wr_addr   = AW'(wa);
      wr_data   = wd;
      rd_addr_a = AW'(ra);
      rd_addr_b = AW'(rb);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rd_addr_a = AW'(0);
      rd_addr_b = AW'(15);
      #1;
      check("rst_valid_before_edge", {15'd0, rd_valid}, 16'h0000);
      check("rst_data_a", rd_data_a, 16'h0000);
      @(negedge clk);
      check("rst_r0", rd_data_a, 16'h0000);
      check("rst_r15", rd_data_b, 16'h0000);
      check("valid_after_edge", {15'd0, rd_valid}, 16'h0001);

      drive(1'b1, 3, 16'hBEEF, 0, 0);
      drive(1'b0, 0, 16'h0000, 3, 3);
      check("beef_a", rd_data_a, 16'hBEEF);
      check("beef_b", rd_data_b, 16'hBEEF);

      drive(1'b1, 5, 16'h1234, 5, 5);
      check("same_cycle_r5", rd_data_a, BYPASS ? 16'h1234 : 16'h0000);
      drive(1'b0, 0, 16'h0000, 5, 7);
      check("r5_next", rd_data_a, 16'h1234);

      drive(1'b0, 7, 16'hAAAA, 7, 7);
      drive(1'b0, 0, 16'h0000, 7, 7);
      check("r7_no_write", rd_data_b, 16'h0000);

      drive(1'b1, 9, 16'h0001, 0, 0);
      drive(1'b1, 9, 16'h0002, 0, 0);
      drive(1'b0, 0, 16'h0000, 9, 9);
      check("r9_last_wins", rd_data_a, 16'h0002);

      for (int i = 0; i < RC; i++) drive(1'b1, i, DW'(i * 16'h1111), 0, 0);
      drive(1'b0, 0, 16'h0000, 10, 15);
      check("fill_r10", rd_data_a, 16'hAAAA);
      check("fill_r15", rd_data_b, 16'hFFFF);

      // Reset lands between edges with a write pending; outputs must clear at once.
      wr_en = 1'b1; wr_addr = AW'(4); wr_data = 16'h5A5A; rd_addr_a = AW'(12); rd_addr_b = AW'(4);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_a", rd_data_a, 16'h0000);
      check("async_rst_b", rd_data_b, 16'h0000);
      check("async_rst_valid", {15'd0, rd_valid}, 16'h0000);
      @(negedge clk);
      wr_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < RC; i++) drive(1'b0, 0, 16'h0000, i, RC - 1 - i);
      drive(1'b0, 0, 16'h0000, 4, 12);
      check("post_rst_r4", rd_data_a, 16'h0000);
      check("post_rst_r12", rd_data_b, 16'h0000);

      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(63) == 0) rst = 1'b1;
         else rst = 1'b0;
         drive($urandom_range(1) == 1, int'($urandom_range(RC - 1)), DW'($urandom),
               int'($urandom_range(RC - 1)), int'($urandom_range(RC - 1)));
      end
      rst = 1'b0;
      drive(1'b0, 0, 16'h0000, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_register_file

`default_nettype wire

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, bits per register.
REQ-002 SHALL have parameter REG_COUNT, default 16, number of registers.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, index width; SHALL equal clog2(REG_COUNT).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  write strobe.
REQ-007 SHALL have port wr_addr  input  ADDR_WIDTH  write index.
REQ-008 SHALL have port wr_data  input  DATA_WIDTH  write value.
REQ-009 SHALL have port rd_addr_a  input  ADDR_WIDTH  read port A index (Rdest operand).
REQ-010 SHALL have port rd_addr_b  input  ADDR_WIDTH  read port B index (Rsrc operand).
REQ-011 SHALL have port rd_data_a  output  DATA_WIDTH  port A value.
REQ-012 SHALL have port rd_data_b  output  DATA_WIDTH  port B value; feeds the register-vs-immediate operand mux.
REQ-013 SHALL have port rd_valid  output  1  high when the read outputs hold data for the addresses presented on the previous cycle.

Function
REQ-014 Reads SHALL be registered: rd_data_a/b SHALL present the contents of rd_addr_a/b sampled at edge N, valid after edge N (latency 1).
REQ-015 Writes SHALL commit at the rising edge where wr_en=1; wr_en=0 SHALL leave all registers unchanged.
REQ-016 All registers, including index 0, SHALL be writable; no hardwired zero register.
REQ-017 wr_addr >= REG_COUNT (only when REG_COUNT < 2^ADDR_WIDTH) SHALL be ignored; the read of such an index SHALL return 0.
REQ-018 Ports A and B SHALL read the same address independently and return identical data.
REQ-019 Read and write to the same address in one cycle: behaviour SHALL follow the Configuration section.
REQ-020 rd_valid SHALL be 0 for the first edge after rst deasserts and 1 thereafter until the next reset.
REQ-021 Only one write port SHALL exist; no write collision case arises.

Reset
REQ-022 rst=1 SHALL immediately, without a clock, clear every register, rd_data_a, rd_data_b and rd_valid to 0.
REQ-023 A write in flight on the edge coincident with rst assertion SHALL be discarded.
REQ-024 rst SHALL override wr_en at all times while asserted.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN: when defined, a same-cycle read and write to one address SHALL return wr_data on the read port (write-before-read forwarding).
REQ-026 Without REGFILE_BYPASS_EN, the read SHALL return the value held before the write (read-before-write); the new value SHALL be visible from the following read.

Structure
REQ-027 DATA_WIDTH, REG_COUNT and ADDR_WIDTH defaults SHALL live in shared package cr16_pkg, together with the processor-wide word type.
REQ-028 One sub-module, register_cell (DATA_WIDTH-wide enable flop with asynchronous clear), SHALL be instantiated REG_COUNT times via generate; read muxing and bypass logic SHALL stay in register_file.

Verification
REQ-029 Assert rst, release, read addresses 0 and 15 -> rd_data_a=rd_data_b=0x0000; rd_valid 0 on first edge, 1 after.
REQ-030 Write 0xBEEF to r3, next cycle read A=3, B=3 -> both 0xBEEF one edge later.
REQ-031 Write 0x1234 to r5 while reading r5 same cycle -> 0x1234 with REGFILE_BYPASS_EN, prior value (0x0000 after reset) without it.
REQ-032 Write 0xAAAA to r7 with wr_en=0 -> r7 read stays 0x0000.
REQ-033 Fill r0..r15 with index*0x1111, then assert rst asynchronously mid-cycle -> all reads and outputs 0x0000 immediately, before next edge.
REQ-034 Back-to-back writes 0x0001 then 0x0002 to r9 -> read of r9 afterwards returns 0x0002.
